mem_port_ctrl: RTL and testbench

Per-processor front end to the shared scratchpad. Accepts one load/store command at a time from a processor over a valid/ready handshake. Drives that processor's request, address, write-data and write-size lanes into the shared memory arbiter, and holds them stable until granted. For loads, captures the returned read bus and presents it on a valid/ready response channel. One instance sits in front of each port of the shared memory.

---
 rtl/shared_mem_pkg.sv | 17 +
 rtl/mem_port_ctrl_if.sv | 31 +++
 rtl/mem_port_ctrl_req_watchdog.sv | 28 ++
 rtl/mem_port_ctrl.sv | 160 ++++++++++++++++
 tb/tb_mem_port_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/shared_mem_pkg.sv
// Shared scratchpad types: address, write-size and port FSM state encodings.
package shared_mem_pkg;

    localparam int ADDR_W = 24;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [2:0]        wr_size_t;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_REQ_RD  = 3'd1,
        ST_RD_CAPT = 3'd2,
        ST_RSP     = 3'd3,
        ST_REQ_WR  = 3'd4
    } mem_port_state_t;

endpackage

// File: rtl/mem_port_ctrl_if.sv
// Processor-facing command/response channel of a scratchpad port.
// master = processor side, slave = mem_port_ctrl side.
interface mem_port_ctrl_if #(
    parameter int BUS_SIZE  = 160,
    parameter int ADDR_SIZE = 24
);
    import shared_mem_pkg::*;

    logic                 i_cmd_valid;
    logic                 o_cmd_ready;
    logic                 i_cmd_we;
    logic [ADDR_SIZE-1:0] i_cmd_addr;
    logic [BUS_SIZE-1:0]  i_cmd_wdata;
    wr_size_t             i_cmd_wsize;

    logic                 o_rsp_valid;
    logic                 i_rsp_ready;
    logic [BUS_SIZE-1:0]  o_rsp_data;
    logic                 o_rsp_err;

    modport master (
        output i_cmd_valid, i_cmd_we, i_cmd_addr, i_cmd_wdata, i_cmd_wsize, i_rsp_ready,
        input  o_cmd_ready, o_rsp_valid, o_rsp_data, o_rsp_err
    );

    modport slave (
        input  i_cmd_valid, i_cmd_we, i_cmd_addr, i_cmd_wdata, i_cmd_wsize, i_rsp_ready,
        output o_cmd_ready, o_rsp_valid, o_rsp_data, o_rsp_err
    );

endinterface

// File: rtl/mem_port_ctrl_req_watchdog.sv
// req_watchdog: counts ungranted request cycles and flags the cycle in which
// the LIMIT-th ungranted cycle occurs. Cleared when a new command is accepted.
module req_watchdog #(
    parameter int unsigned LIMIT = 256
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);
    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] cnt;

    // Count ungranted cycles; clear on command entry.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            cnt <= '0;
        end else if (i_en) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Expiry only in an ungranted cycle, so a grant arriving on the limit wins.
    assign o_expire = i_en && (cnt == CW'(LIMIT - 1));

endmodule

// File: rtl/mem_port_ctrl.sv
// mem_port_ctrl: per-processor front end to the shared scratchpad.
// Takes one load/store at a time, holds the request lanes to the arbiter until
// granted, captures load data and returns it on a valid/ready response.
// Optional grant-wait timeout: define MEM_PORT_TIMEOUT_EN.
module mem_port_ctrl
    import shared_mem_pkg::*;
#(
    parameter int BUS_SIZE       = 160,
    parameter int UNIT_SIZE      = 32,
    parameter int ADDR_SIZE      = 24,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    mem_port_ctrl_if.slave       port,
    output logic                 o_req_rd,
    output logic                 o_req_wr,
    input  logic                 i_grant_rd,
    input  logic                 i_grant_wr,
    output logic [ADDR_SIZE-1:0] o_addr,
    output logic [BUS_SIZE-1:0]  o_wdata,
    output wr_size_t             o_wsize,
    input  logic [BUS_SIZE-1:0]  i_rd_data,
    output logic                 o_busy,
    output logic                 o_timeout
);
    localparam int WORDS = BUS_SIZE / UNIT_SIZE;

    // Command registers; direction is carried by the FSM state itself.
    typedef struct packed {
        logic [ADDR_SIZE-1:0] addr;
        logic [BUS_SIZE-1:0]  wdata;
        wr_size_t             wsize;
    } cmd_t;

    mem_port_state_t              state_q;
    cmd_t                         cmd_q;
    logic [WORDS-1:0][UNIT_SIZE-1:0] rsp_words_q;
    logic cmd_ready_q, req_rd_q, req_wr_q, rsp_valid_q, rsp_err_q, busy_q, timeout_q;
    logic accept, wd_expire;

    assign accept = (state_q == ST_IDLE) && port.i_cmd_valid && cmd_ready_q;

`ifdef MEM_PORT_TIMEOUT_EN
    logic wd_en;

    // Only ungranted request cycles count toward the limit.
    assign wd_en = ((state_q == ST_REQ_RD) && !i_grant_rd) ||
                   ((state_q == ST_REQ_WR) && !i_grant_wr);

    req_watchdog #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_watchdog (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_clr    (accept),
        .i_en     (wd_en),
        .o_expire (wd_expire)
    );
`else
    // No watchdog: requests wait for a grant indefinitely.
    assign wd_expire = 1'b0;
`endif

    // Port FSM with all handshake/request outputs registered.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= ST_IDLE;
            cmd_q       <= '0;
            rsp_words_q <= '0;
            cmd_ready_q <= 1'b0;
            req_rd_q    <= 1'b0;
            req_wr_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            busy_q      <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        cmd_q       <= '{addr:  port.i_cmd_addr,
                                         wdata: port.i_cmd_wdata,
                                         wsize: port.i_cmd_wsize};
                        cmd_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        if (port.i_cmd_we) begin
                            state_q  <= ST_REQ_WR;
                            req_wr_q <= 1'b1;
                        end else begin
                            state_q  <= ST_REQ_RD;
                            req_rd_q <= 1'b1;
                        end
                    end else begin
                        cmd_ready_q <= 1'b1;
                    end
                end
                ST_REQ_RD: begin
                    if (i_grant_rd) begin
                        req_rd_q <= 1'b0;
                        state_q  <= ST_RD_CAPT;
                    end else if (wd_expire) begin
                        // Abandoned load still answers, flagged as an error with zero data.
                        req_rd_q    <= 1'b0;
                        timeout_q   <= 1'b1;
                        rsp_words_q <= '0;
                        rsp_err_q   <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        state_q     <= ST_RSP;
                    end
                end
                ST_RD_CAPT: begin
                    rsp_words_q <= i_rd_data;
                    rsp_err_q   <= 1'b0;
                    rsp_valid_q <= 1'b1;
                    state_q     <= ST_RSP;
                end
                ST_RSP: begin
                    if (port.i_rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        rsp_err_q   <= 1'b0;
                        busy_q      <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                ST_REQ_WR: begin
                    // Stores are posted: done once granted (or dropped on timeout).
                    if (i_grant_wr || wd_expire) begin
                        timeout_q   <= !i_grant_wr;
                        req_wr_q    <= 1'b0;
                        busy_q      <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Memory lanes carry the held command only while a command is in flight.
    assign o_addr  = busy_q ? cmd_q.addr  : '0;
    assign o_wdata = busy_q ? cmd_q.wdata : '0;
    assign o_wsize = busy_q ? cmd_q.wsize : '0;

    assign o_req_rd  = req_rd_q;
    assign o_req_wr  = req_wr_q;
    assign o_busy    = busy_q;
    assign o_timeout = timeout_q;

    assign port.o_cmd_ready = cmd_ready_q;
    assign port.o_rsp_valid = rsp_valid_q;
    assign port.o_rsp_data  = rsp_words_q;
    assign port.o_rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_mem_port_ctrl.sv
// Directed bench for mem_port_ctrl. Control outputs are packed into ctl =
// {cmd_ready, req_rd, req_wr, rsp_valid, rsp_err, busy, timeout}.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_mem_port_ctrl;
    localparam int BUS = 160;
    localparam int AW  = 24;
    localparam int TO  = 8;

    localparam logic [6:0] C_RST  = 7'b0000000;
    localparam logic [6:0] C_IDLE = 7'b1000000;
    localparam logic [6:0] C_RDQ  = 7'b0100010;
    localparam logic [6:0] C_CAPT = 7'b0000010;
    localparam logic [6:0] C_RSP  = 7'b0001010;
    localparam logic [6:0] C_WRQ  = 7'b0010010;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic           req_rd, req_wr, grant_rd, grant_wr, busy, timeout;
    logic [AW-1:0]  addr;
    logic [BUS-1:0] wdata, rd_data;
    logic [2:0]     wsize;
    logic [6:0]     ctl;

    int n_checks = 0;
    int n_fail   = 0;

    mem_port_ctrl_if #(.BUS_SIZE(BUS), .ADDR_SIZE(AW)) cmd_if ();

    mem_port_ctrl #(
        .BUS_SIZE(BUS), .UNIT_SIZE(32), .ADDR_SIZE(AW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .i_clk(clk), .i_rst(rst), .port(cmd_if),
        .o_req_rd(req_rd), .o_req_wr(req_wr),
        .i_grant_rd(grant_rd), .i_grant_wr(grant_wr),
        .o_addr(addr), .o_wdata(wdata), .o_wsize(wsize),
        .i_rd_data(rd_data), .o_busy(busy), .o_timeout(timeout)
    );

    assign ctl = {cmd_if.o_cmd_ready, req_rd, req_wr, cmd_if.o_rsp_valid,
                  cmd_if.o_rsp_err, busy, timeout};

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic issue(input logic we, input logic [AW-1:0] a,
                         input logic [BUS-1:0] d, input logic [2:0] sz);
        cmd_if.i_cmd_valid = 1'b1;
        cmd_if.i_cmd_we    = we;
        cmd_if.i_cmd_addr  = a;
        cmd_if.i_cmd_wdata = d;
        cmd_if.i_cmd_wsize = sz;
    endtask

    task automatic test_reset();
        cmd_if.i_cmd_valid = 1'b0; cmd_if.i_cmd_we = 1'b0; cmd_if.i_cmd_addr = '0;
        cmd_if.i_cmd_wdata = '0;   cmd_if.i_cmd_wsize = '0; cmd_if.i_rsp_ready = 1'b0;
        grant_rd = 1'b0; grant_wr = 1'b0; rd_data = '0;
        rst = 1'b1;
        tick();
        n_checks++;
        if ({ctl, addr, cmd_if.o_rsp_data} !== {C_RST, {AW{1'b0}}, {BUS{1'b0}}}) begin
            n_fail++; $display("FAIL reset_state: ctl=%b addr=%h", ctl, addr);
        end
        rst = 1'b0;
        tick();
        n_checks++;
        if (ctl !== C_IDLE) begin n_fail++; $display("FAIL reset_release: ctl=%b expected %b", ctl, C_IDLE); end
    endtask

    task automatic test_load();
        logic [BUS-1:0] pat;
        pat = {20{8'hA5}};
        issue(1'b0, 24'h000010, '0, 3'd0);
        rd_data = ~pat;
        tick();                                   // T+1
        cmd_if.i_cmd_valid = 1'b0;
        n_checks++;
        if ({ctl, addr} !== {C_RDQ, 24'h000010}) begin
            n_fail++; $display("FAIL load_req: ctl=%b addr=%h expected %b 000010", ctl, addr, C_RDQ);
        end
        grant_rd = 1'b1;
        tick();                                   // T+2 capture
        grant_rd = 1'b0;
        rd_data = pat;
        n_checks++;
        if (ctl !== C_CAPT) begin n_fail++; $display("FAIL load_capt: ctl=%b expected %b", ctl, C_CAPT); end
        tick();                                   // T+3 response
        rd_data = '0;
        n_checks++;
        if ({ctl, cmd_if.o_rsp_data} !== {C_RSP, pat}) begin
            n_fail++; $display("FAIL load_rsp: ctl=%b data=%h expected %b %h", ctl, cmd_if.o_rsp_data, C_RSP, pat);
        end
        cmd_if.i_rsp_ready = 1'b1;
        tick();
        cmd_if.i_rsp_ready = 1'b0;
        n_checks++;
        if ({ctl, addr} !== {C_IDLE, {AW{1'b0}}}) begin
            n_fail++; $display("FAIL load_done: ctl=%b addr=%h expected %b 0", ctl, addr, C_IDLE);
        end
    endtask

    task automatic test_store_wait();
        logic [BUS-1:0] wd;
        wd = {32'h0BAD_F00D, 32'h1111_2222, 32'h3333_4444, 32'h5555_6666, 32'h7777_8888};
        issue(1'b1, 24'h000020, wd, 3'd5);
        tick();
        cmd_if.i_cmd_valid = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            n_checks++;
            if ({ctl, addr, wsize, wdata} !== {C_WRQ, 24'h000020, 3'd5, wd}) begin
                n_fail++; $display("FAIL store_wait[%0d]: ctl=%b addr=%h wsize=%0d wdata=%h", k, ctl, addr, wsize, wdata);
            end
            grant_wr = (k == 5);
            tick();
        end
        grant_wr = 1'b0;
        n_checks++;
        if ({ctl, wdata} !== {C_IDLE, {BUS{1'b0}}}) begin
            n_fail++; $display("FAIL store_done: ctl=%b expected %b", ctl, C_IDLE);
        end
    endtask

    task automatic test_rsp_stall();
        logic [BUS-1:0] pat;
        pat = {5{32'hC0DE_0042}};
        issue(1'b0, 24'h000030, '0, 3'd0);
        tick();
        cmd_if.i_cmd_valid = 1'b0;
        grant_rd = 1'b1;
        tick();
        grant_rd = 1'b0;
        rd_data = pat;
        tick();                                   // RSP
        issue(1'b1, 24'h000040, {BUS{1'b1}}, 3'd2);  // pending store waits for handshake
        for (int k = 1; k <= 3; k++) begin
            rd_data = {BUS{1'b0}} | k;
            n_checks++;
            if ({ctl, cmd_if.o_rsp_data} !== {C_RSP, pat}) begin
                n_fail++; $display("FAIL rsp_stall[%0d]: ctl=%b data=%h expected %b %h", k, ctl, cmd_if.o_rsp_data, C_RSP, pat);
            end
            tick();
        end
        cmd_if.i_rsp_ready = 1'b1;
        tick();
        cmd_if.i_rsp_ready = 1'b0;
        n_checks++;
        if (ctl !== C_IDLE) begin n_fail++; $display("FAIL rsp_release: ctl=%b expected %b", ctl, C_IDLE); end
        tick();
        cmd_if.i_cmd_valid = 1'b0;
        n_checks++;
        if ({ctl, addr} !== {C_WRQ, 24'h000040}) begin
            n_fail++; $display("FAIL next_accept: ctl=%b addr=%h expected %b 000040", ctl, addr, C_WRQ);
        end
        grant_wr = 1'b1;
        tick();
        grant_wr = 1'b0;
        n_checks++;
        if (ctl !== C_IDLE) begin n_fail++; $display("FAIL next_done: ctl=%b expected %b", ctl, C_IDLE); end
    endtask

    task automatic test_stray_grant();
        grant_rd = 1'b1; grant_wr = 1'b1;
        tick();
        grant_rd = 1'b0; grant_wr = 1'b0;
        n_checks++;
        if (ctl !== C_IDLE) begin n_fail++; $display("FAIL stray_idle: ctl=%b expected %b", ctl, C_IDLE); end
        issue(1'b0, 24'h000050, '0, 3'd0);
        tick();
        cmd_if.i_cmd_valid = 1'b0;
        grant_wr = 1'b1;
        tick();
        grant_wr = 1'b0;
        n_checks++;
        if ({ctl, addr} !== {C_RDQ, 24'h000050}) begin
            n_fail++; $display("FAIL stray_wr_in_rd: ctl=%b addr=%h expected %b 000050", ctl, addr, C_RDQ);
        end
        grant_rd = 1'b1;
        tick();
        grant_rd = 1'b0;
        rd_data = {BUS{1'b1}};
        tick();
        n_checks++;
        if ({ctl, cmd_if.o_rsp_data} !== {C_RSP, {BUS{1'b1}}}) begin
            n_fail++; $display("FAIL stray_rsp: ctl=%b data=%h", ctl, cmd_if.o_rsp_data);
        end
        cmd_if.i_rsp_ready = 1'b1;
        tick();
        cmd_if.i_rsp_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        issue(1'b0, 24'h000060, '0, 3'd0);
        tick();
        cmd_if.i_cmd_valid = 1'b0;
        rst = 1'b1;                               // reset while in REQ_RD
        tick();
        rst = 1'b0;
        n_checks++;
        if ({ctl, addr} !== {C_RST, {AW{1'b0}}}) begin
            n_fail++; $display("FAIL rst_in_req: ctl=%b addr=%h expected %b 0", ctl, addr, C_RST);
        end
        tick();
        n_checks++;
        if (ctl !== C_IDLE) begin n_fail++; $display("FAIL rst_req_after: ctl=%b expected %b", ctl, C_IDLE); end
        issue(1'b0, 24'h000070, '0, 3'd0);
        tick();
        cmd_if.i_cmd_valid = 1'b0;
        grant_rd = 1'b1;
        tick();
        grant_rd = 1'b0;
        rd_data = {5{32'h1234_5678}};
        tick();
        n_checks++;
        if (ctl !== C_RSP) begin n_fail++; $display("FAIL rst_pre_rsp: ctl=%b expected %b", ctl, C_RSP); end
        rst = 1'b1;                               // reset while in RSP
        tick();
        rst = 1'b0;
        n_checks++;
        if ({ctl, cmd_if.o_rsp_data} !== {C_RST, {BUS{1'b0}}}) begin
            n_fail++; $display("FAIL rst_in_rsp: ctl=%b data=%h expected %b 0", ctl, cmd_if.o_rsp_data, C_RST);
        end
        tick();
        n_checks++;
        if (ctl !== C_IDLE) begin n_fail++; $display("FAIL rst_rsp_after: ctl=%b expected %b", ctl, C_IDLE); end
    endtask

`ifdef MEM_PORT_TIMEOUT_EN
    task automatic test_timeout();
        // Grant on the expiry cycle: normal response, no timeout.
        issue(1'b0, 24'h000080, '0, 3'd0);
        tick();
        cmd_if.i_cmd_valid = 1'b0;
        for (int k = 1; k <= TO; k++) begin
            grant_rd = (k == TO);
            tick();
        end
        grant_rd = 1'b0;
        n_checks++;
        if (ctl !== C_CAPT) begin n_fail++; $display("FAIL to_grant_wins: ctl=%b expected %b", ctl, C_CAPT); end
        rd_data = {5{32'hFACE_B00C}};
        tick();
        n_checks++;
        if ({ctl, cmd_if.o_rsp_data} !== {C_RSP, {5{32'hFACE_B00C}}}) begin
            n_fail++; $display("FAIL to_grant_rsp: ctl=%b data=%h", ctl, cmd_if.o_rsp_data);
        end
        cmd_if.i_rsp_ready = 1'b1;
        tick();
        cmd_if.i_rsp_ready = 1'b0;
        // Load never granted.
        issue(1'b0, 24'h000090, '0, 3'd0);
        tick();
        cmd_if.i_cmd_valid = 1'b0;
        for (int k = 1; k <= TO; k++) begin
            n_checks++;
            if (ctl !== C_RDQ) begin n_fail++; $display("FAIL to_ld_wait[%0d]: ctl=%b expected %b", k, ctl, C_RDQ); end
            tick();
        end
        n_checks++;
        if ({ctl, cmd_if.o_rsp_data} !== {7'b0001111, {BUS{1'b0}}}) begin
            n_fail++; $display("FAIL to_ld_expire: ctl=%b data=%h expected 0001111 0", ctl, cmd_if.o_rsp_data);
        end
        tick();
        n_checks++;
        if (ctl !== 7'b0001110) begin n_fail++; $display("FAIL to_ld_pulse: ctl=%b expected 0001110", ctl); end
        cmd_if.i_rsp_ready = 1'b1;
        tick();
        cmd_if.i_rsp_ready = 1'b0;
        // Store never granted: dropped.
        issue(1'b1, 24'h0000A0, {BUS{1'b1}}, 3'd1);
        tick();
        cmd_if.i_cmd_valid = 1'b0;
        for (int k = 1; k <= TO; k++) tick();
        n_checks++;
        if (ctl !== 7'b1000001) begin n_fail++; $display("FAIL to_st_expire: ctl=%b expected 1000001", ctl); end
        tick();
        n_checks++;
        if (ctl !== C_IDLE) begin n_fail++; $display("FAIL to_st_after: ctl=%b expected %b", ctl, C_IDLE); end
    endtask
`else
    task automatic test_no_timeout();
        issue(1'b1, 24'h0000B0, {BUS{1'b1}}, 3'd3);
        tick();
        cmd_if.i_cmd_valid = 1'b0;
        for (int k = 1; k <= 3 * TO; k++) begin
            n_checks++;
            if (ctl !== C_WRQ) begin n_fail++; $display("FAIL no_to_wait[%0d]: ctl=%b expected %b", k, ctl, C_WRQ); end
            tick();
        end
        grant_wr = 1'b1;
        tick();
        grant_wr = 1'b0;
        n_checks++;
        if (ctl !== C_IDLE) begin n_fail++; $display("FAIL no_to_done: ctl=%b expected %b", ctl, C_IDLE); end
    endtask
`endif

    initial begin
        test_reset();
        test_load();
        test_store_wait();
        test_rsp_stall();
        test_stray_grant();
        test_reset_mid();
`ifdef MEM_PORT_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
